// File: rtl/multi_bit_sync_pkg.sv
// Shared constants for the multi-channel level synchroniser: per-channel
// edge-decode modes and a constant-function clog2 for counter sizing.
package multi_bit_sync_pkg;

  localparam logic [1:0] MODE_LEVEL = 2'd0;
  localparam logic [1:0] MODE_RISE  = 2'd1;
  localparam logic [1:0] MODE_FALL  = 2'd2;
  localparam logic [1:0] MODE_ANY   = 2'd3;

  // Smallest n such that 2**n >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/multi_bit_sync_chan.sv
// One synchroniser channel: flop chain, optional stability filter,
// registered edge decode and a sticky event flag.
module sync_chan
  import multi_bit_sync_pkg::*;
#(
  parameter int         NUM_STAGES = 2,
  parameter int         FILT_LEN   = 0,
  parameter logic [1:0] MODE       = MODE_LEVEL
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  input  logic evt_clr,
  output logic sync_out,
  output logic pulse_out,
  output logic evt_sticky
);

  logic [NUM_STAGES-1:0] chain;
  logic                  s;
  logic                  f;
  logic                  f_d;
  logic                  pulse;
  logic                  sticky;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[NUM_STAGES-2:0], async_in};
  end

  assign s = chain[NUM_STAGES-1];

  generate
    if (FILT_LEN == 0) begin : g_no_filt
      assign f = s;
    end else begin : g_filt
      localparam int            CW   = clog2(FILT_LEN + 1);
      localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

      logic [CW-1:0] cnt;
      logic          f_q;

      // f only moves after s has disagreed with it for FILT_LEN straight cycles.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt <= '0;
          f_q <= 1'b0;
        end else if (s == f_q) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt <= '0;
          f_q <= s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign f = f_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) f_d <= 1'b0;
    else        f_d <= f;
  end

  always_comb begin
    pulse = 1'b0;
    case (MODE)
      MODE_RISE: pulse = f & ~f_d;
      MODE_FALL: pulse = ~f & f_d;
      MODE_ANY:  pulse = f ^ f_d;
      default:   pulse = 1'b0;
    endcase
  end

  // A pulse in the same cycle as a clear wins, so no event is ever lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       sticky <= 1'b0;
    else if (pulse)   sticky <= 1'b1;
    else if (evt_clr) sticky <= 1'b0;
  end

  assign sync_out   = f;
  assign pulse_out  = pulse;
  assign evt_sticky = sticky;

endmodule

// File: rtl/multi_bit_sync.sv
// Bank of NUM_CH independent level synchronisers; channels share only the
// clock and reset, so no cross-channel coherency is implied.
module multi_bit_sync
  import multi_bit_sync_pkg::*;
#(
  parameter int                NUM_STAGES = 2,
  parameter int                NUM_CH     = 4,
  parameter int                FILT_LEN   = 0,
  parameter logic [2*NUM_CH-1:0] MODE     = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] async_in,
  input  logic [NUM_CH-1:0] evt_clr,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] evt_sticky
);

  generate
    if (NUM_STAGES < 2) begin : g_bad_stages
      $error("multi_bit_sync: NUM_STAGES must be >= 2");
    end
    if (NUM_CH < 1) begin : g_bad_ch
      $error("multi_bit_sync: NUM_CH must be >= 1");
    end
    if (FILT_LEN < 0) begin : g_bad_filt
      $error("multi_bit_sync: FILT_LEN must be >= 0");
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_chan
      sync_chan #(
        .NUM_STAGES (NUM_STAGES),
        .FILT_LEN   (FILT_LEN),
        .MODE       (MODE[2*i +: 2])
      ) u_chan (
        .clk        (clk),
        .reset      (reset),
        .async_in   (async_in[i]),
        .evt_clr    (evt_clr[i]),
        .sync_out   (sync_out[i]),
        .pulse_out  (pulse_out[i]),
        .evt_sticky (evt_sticky[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_bit_sync.sv
// Bench for multi_bit_sync: an unfiltered and a filtered instance, directed
// scenarios plus random traffic against a window-based reference model.
module tb_multi_bit_sync;
  import multi_bit_sync_pkg::*;

  localparam int         NS     = 2;
  localparam int         LA     = 0;
  localparam int         LB     = 4;
  localparam logic [7:0] MODE_A = {MODE_LEVEL, MODE_ANY, MODE_FALL, MODE_RISE};
  localparam logic [7:0] MODE_B = {MODE_ANY, MODE_FALL, MODE_RISE, MODE_LEVEL};

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_a = '0, clr_a = '0, in_b = '0, clr_b = '0;
  logic [3:0] sync_a, pulse_a, sticky_a, sync_b, pulse_b, sticky_b;
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  multi_bit_sync #(.NUM_STAGES(NS), .NUM_CH(4), .FILT_LEN(LA), .MODE(MODE_A)) dut_a (
    .clk(clk), .reset(reset), .async_in(in_a), .evt_clr(clr_a),
    .sync_out(sync_a), .pulse_out(pulse_a), .evt_sticky(sticky_a)
  );

  multi_bit_sync #(.NUM_STAGES(NS), .NUM_CH(4), .FILT_LEN(LB), .MODE(MODE_B)) dut_b (
    .clk(clk), .reset(reset), .async_in(in_b), .evt_clr(clr_b),
    .sync_out(sync_b), .pulse_out(pulse_b), .evt_sticky(sticky_b)
  );

  // Reference model: per-channel history of sampled inputs; the filtered level
  // flips once the last FILT_LEN synced samples all disagree with it.
  logic [15:0] hist [2][4];
  logic        mf   [2][4];
  logic        mfp  [2][4];
  logic        mst  [2][4];

  function automatic logic [1:0] mode_of(input int d, input int c);
    return (d == 0) ? MODE_A[2*c +: 2] : MODE_B[2*c +: 2];
  endfunction

  function automatic logic rule(input logic [1:0] m, input logic cur, input logic prev);
    case (m)
      MODE_RISE: return cur & ~prev;
      MODE_FALL: return ~cur & prev;
      MODE_ANY:  return cur ^ prev;
      default:   return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 4; c++) begin
          hist[d][c] = '0;
          mf[d][c]   = 1'b0;
          mfp[d][c]  = 1'b0;
          mst[d][c]  = 1'b0;
        end
    end else begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 4; c++) begin
          logic in_v, clr_v, nf, all_v;
          int   len;
          in_v  = (d == 0) ? in_a[c] : in_b[c];
          clr_v = (d == 0) ? clr_a[c] : clr_b[c];
          len   = (d == 0) ? LA : LB;
          if (rule(mode_of(d, c), mf[d][c], mfp[d][c])) mst[d][c] = 1'b1;
          else if (clr_v)                               mst[d][c] = 1'b0;
          hist[d][c] = {hist[d][c][14:0], in_v};
          nf = mf[d][c];
          if (len == 0) nf = hist[d][c][NS-1];
          else begin
            all_v = 1'b1;
            for (int j = 1; j <= len; j++)
              if (hist[d][c][NS-1+j] == mf[d][c]) all_v = 1'b0;
            if (all_v) nf = ~mf[d][c];
          end
          mfp[d][c] = mf[d][c];
          mf[d][c]  = nf;
        end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (sync_a   !== 4'h0) $display("FAIL reset_sync_a: got %b expected 0000", sync_a);   else passes++;
    checks++; if (pulse_a  !== 4'h0) $display("FAIL reset_pulse_a: got %b expected 0000", pulse_a); else passes++;
    checks++; if (sticky_a !== 4'h0) $display("FAIL reset_sticky_a: got %b expected 0000", sticky_a); else passes++;
    checks++; if (sync_b   !== 4'h0) $display("FAIL reset_sync_b: got %b expected 0000", sync_b);   else passes++;
    checks++; if (pulse_b  !== 4'h0) $display("FAIL reset_pulse_b: got %b expected 0000", pulse_b); else passes++;
    checks++; if (sticky_b !== 4'h0) $display("FAIL reset_sticky_b: got %b expected 0000", sticky_b); else passes++;
    reset = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_rise_latency();
    in_a[0] = 1'b1;
    tick();
    checks++; if (sync_a[0] !== 1'b0) $display("FAIL rise_sync_c1: got %b expected 0", sync_a[0]); else passes++;
    tick();
    checks++; if ({sync_a[0], pulse_a[0], sticky_a[0]} !== 3'b110)
      $display("FAIL rise_c2 sync/pulse/sticky: got %b expected 110", {sync_a[0], pulse_a[0], sticky_a[0]}); else passes++;
    tick();
    checks++; if ({sync_a[0], pulse_a[0], sticky_a[0]} !== 3'b101)
      $display("FAIL rise_c3 sync/pulse/sticky: got %b expected 101", {sync_a[0], pulse_a[0], sticky_a[0]}); else passes++;
  endtask

  task automatic test_sticky_clr();
    clr_a[0] = 1'b1;
    tick();
    clr_a[0] = 1'b0;
    checks++; if (sticky_a[0] !== 1'b0) $display("FAIL clr_plain: got %b expected 0", sticky_a[0]); else passes++;
    in_a[0] = 1'b0;
    repeat (5) tick();
    in_a[0] = 1'b1;
    repeat (2) tick();
    checks++; if (pulse_a[0] !== 1'b1) $display("FAIL clr_pulse: got %b expected 1", pulse_a[0]); else passes++;
    clr_a[0] = 1'b1;
    tick();
    checks++; if (sticky_a[0] !== 1'b1) $display("FAIL clr_set_wins: got %b expected 1", sticky_a[0]); else passes++;
    tick();
    clr_a[0] = 1'b0;
    checks++; if (sticky_a[0] !== 1'b0) $display("FAIL clr_lone: got %b expected 0", sticky_a[0]); else passes++;
  endtask

  task automatic test_glitch();
    in_b[1] = 1'b1;
    repeat (3) tick();
    in_b[1] = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      checks++; if ({sync_b[1], pulse_b[1], sticky_b[1]} !== 3'b000)
        $display("FAIL glitch3 t%0d: got %b expected 000", t, {sync_b[1], pulse_b[1], sticky_b[1]}); else passes++;
    end
    in_b[1] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 4) in_b[1] = 1'b0;
      if (t == 5) begin
        checks++; if (sync_b[1] !== 1'b0) $display("FAIL hold4_c5: got %b expected 0", sync_b[1]); else passes++;
      end
      if (t == 6) begin
        checks++; if ({sync_b[1], pulse_b[1]} !== 2'b11)
          $display("FAIL hold4_c6 sync/pulse: got %b expected 11", {sync_b[1], pulse_b[1]}); else passes++;
      end
    end
    repeat (10) tick();
  endtask

  task automatic test_any_toggle();
    int   n_pulse;
    logic prev;
    n_pulse = 0;
    prev    = 1'b0;
    in_a[2] = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 10) in_a[2] = 1'b0;
      if (t == 20) in_a[2] = 1'b1;
      if (pulse_a[2] === 1'b1) n_pulse++;
      checks++; if (prev === 1'b1 && pulse_a[2] === 1'b1)
        $display("FAIL any_width t%0d: got 1 expected 0", t); else passes++;
      prev = pulse_a[2];
    end
    checks++; if (n_pulse != 3) $display("FAIL any_count: got %0d expected 3", n_pulse); else passes++;
  endtask

  task automatic test_reset_mid();
    in_b[1] = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    checks++; if ({sync_b, pulse_b, sticky_b} !== 12'h0)
      $display("FAIL midreset_b: got %h expected 000", {sync_b, pulse_b, sticky_b}); else passes++;
    checks++; if ({sync_a, pulse_a, sticky_a} !== 12'h0)
      $display("FAIL midreset_a: got %h expected 000", {sync_a, pulse_a, sticky_a}); else passes++;
    repeat (2) tick();
    reset = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 5) begin
        checks++; if (pulse_b[1] !== 1'b0) $display("FAIL relrise_c5: got %b expected 0", pulse_b[1]); else passes++;
      end
      if (t == 6) begin
        checks++; if ({sync_b[1], pulse_b[1]} !== 2'b11)
          $display("FAIL relrise_c6 sync/pulse: got %b expected 11", {sync_b[1], pulse_b[1]}); else passes++;
      end
      if (t == 7) begin
        checks++; if (pulse_b[1] !== 1'b0) $display("FAIL relrise_c7: got %b expected 0", pulse_b[1]); else passes++;
      end
    end
  endtask

  task automatic test_all_fall();
    in_b = 4'hF;
    repeat (12) tick();
    in_b = 4'h0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 5) begin
        checks++; if ({sync_b, pulse_b} !== 8'hF0)
          $display("FAIL fall_c5 sync/pulse: got %b expected 11110000", {sync_b, pulse_b}); else passes++;
      end
      if (t == 6) begin
        checks++; if ({sync_b, pulse_b} !== 8'h0C)
          $display("FAIL fall_c6 sync/pulse: got %b expected 00001100", {sync_b, pulse_b}); else passes++;
      end
      if (t == 7) begin
        checks++; if (pulse_b !== 4'h0) $display("FAIL fall_c7 pulse: got %b expected 0000", pulse_b); else passes++;
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        logic [3:0] es, ep, ek, as, ap, ak;
        for (int c = 0; c < 4; c++) begin
          es[c] = mf[d][c];
          ep[c] = rule(mode_of(d, c), mf[d][c], mfp[d][c]);
          ek[c] = mst[d][c];
        end
        as = (d == 0) ? sync_a : sync_b;
        ap = (d == 0) ? pulse_a : pulse_b;
        ak = (d == 0) ? sticky_a : sticky_b;
        checks++; if (as !== es) $display("FAIL rand_sync d%0d n%0d: got %b expected %b", d, n, as, es); else passes++;
        checks++; if (ap !== ep) $display("FAIL rand_pulse d%0d n%0d: got %b expected %b", d, n, ap, ep); else passes++;
        checks++; if (ak !== ek) $display("FAIL rand_sticky d%0d n%0d: got %b expected %b", d, n, ak, ek); else passes++;
      end
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 5) == 0) in_a[c] = ~in_a[c];
        if ($urandom_range(0, 3) == 0) in_b[c] = ~in_b[c];
        clr_a[c] = ($urandom_range(0, 7) == 0);
        clr_b[c] = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    test_reset();
    test_rise_latency();
    test_sticky_clr();
    test_glitch();
    test_any_toggle();
    test_reset_mid();
    test_all_fall();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
